// File: rtl/cmd_rback_arbiter_pkg.sv
// rtl/cmd_rback_arbiter_pkg.sv - shared types and constants for the readback burst arbiter
package cmd_rback_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

  // Cycles from rb_ren to valid rb_rdata; also sets the DRAIN length and tag pipeline depth.
  localparam int RBACK_RD_LATENCY = 2;

endpackage

// File: rtl/cmd_rback_arbiter_pick.sv
// rtl/cmd_rback_arbiter_pick.sv - two-way arbitration decision (round-robin with CMD_RBACK_ARB_RR_EN, else fixed priority)
module cmd_rback_arb_pick
  import cmd_rback_arbiter_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  req_idx_t ptr,
  output req_idx_t winner
);

`ifdef CMD_RBACK_ARB_RR_EN
  // ptr names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) winner = ptr;
    else if (req1)    winner = 1'b1;
  end
`else
  req_idx_t unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    winner = 1'b0;
    if (!req0 && req1) winner = 1'b1;
  end
`endif

endmodule

// File: rtl/cmd_rback_arbiter.sv
// rtl/cmd_rback_arbiter.sv - two-requester burst arbiter for the shared readback RAM read port
// Round-robin arbitration when CMD_RBACK_ARB_RR_EN is defined, fixed priority (req0 first) otherwise.
module cmd_rback_arbiter
  import cmd_rback_arbiter_pkg::*;
#(
  parameter int CONTROL_RBACK_DEPTH = 10,
  parameter int LEN_BITS            = 8
) (
  input  logic                           rst,
  input  logic                           axi_clk,
  input  logic                           req0,
  input  logic                           req1,
  input  logic [CONTROL_RBACK_DEPTH-1:0] addr0,
  input  logic [CONTROL_RBACK_DEPTH-1:0] addr1,
  input  logic [LEN_BITS-1:0]            len0,
  input  logic [LEN_BITS-1:0]            len1,
  output logic                           gnt0,
  output logic                           gnt1,
  output logic                           dvalid0,
  output logic                           dvalid1,
  output logic                           dlast,
  output logic [31:0]                    rdata,
  output logic [CONTROL_RBACK_DEPTH-1:0] rb_raddr,
  output logic                           rb_ren,
  input  logic [31:0]                    rb_rdata,
  output logic                           busy
);

  localparam int L = RBACK_RD_LATENCY;

  arb_state_t          state;
  req_idx_t            owner;
  req_idx_t            ptr;
  req_idx_t            winner;
  logic [LEN_BITS-1:0] cnt;
  logic [1:0]          drain_cnt;
  logic [L-1:0]        vld_pipe;
  logic [L-1:0]        tag_pipe;
  logic [L-1:0]        last_pipe;

  cmd_rback_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .ptr    (ptr),
    .winner (winner)
  );

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      cnt       <= '0;
      drain_cnt <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rb_ren    <= 1'b0;
      rb_raddr  <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt0     <= (winner == 1'b0);
            gnt1     <= (winner == 1'b1);
            owner    <= winner;
            ptr      <= ~winner;
            rb_raddr <= winner ? addr1 : addr0;
            cnt      <= winner ? len1 : len0;
            rb_ren   <= 1'b1;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (cnt == '0) begin
            rb_ren    <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            cnt      <= cnt - 1'b1;
            rb_raddr <= rb_raddr + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'(L - 1)) state <= ST_IDLE;
          else                        drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Owner and last-word tags ride alongside each read so returning data is steered correctly.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[L-2:0], rb_ren};
      tag_pipe  <= {tag_pipe[L-2:0], owner};
      last_pipe <= {last_pipe[L-2:0], rb_ren && (cnt == '0)};
    end
  end

  assign dvalid0 = vld_pipe[L-1] && !tag_pipe[L-1];
  assign dvalid1 = vld_pipe[L-1] &&  tag_pipe[L-1];
  assign dlast   = vld_pipe[L-1] && last_pipe[L-1];
  assign rdata   = rb_rdata;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_cmd_rback_arbiter.sv
// tb/tb_cmd_rback_arbiter.sv - self-checking bench for cmd_rback_arbiter with a burst-schedule model
module tb_cmd_rback_arbiter;

  localparam int AW = 10;
  localparam int LW = 8;

  logic          axi_clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic          gnt0, gnt1, dvalid0, dvalid1, dlast, rb_ren, busy;
  logic [31:0]   rdata;
  logic [31:0]   rb_rdata = '0;
  logic [AW-1:0] rb_raddr;

  always #5 axi_clk = ~axi_clk;

  cmd_rback_arbiter #(.CONTROL_RBACK_DEPTH(AW), .LEN_BITS(LW)) dut (
    .rst(rst), .axi_clk(axi_clk),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .dvalid0(dvalid0), .dvalid1(dvalid1), .dlast(dlast),
    .rdata(rdata), .rb_raddr(rb_raddr), .rb_ren(rb_ren), .rb_rdata(rb_rdata), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
    return 32'hC0DE0000 ^ {22'd0, a};
  endfunction

  // Two-register RAM: address sampled with rb_ren, data registered one cycle later.
  logic [31:0] ram_q = '0;
  logic        ren_d = 1'b0;
  always @(posedge axi_clk) begin
    if (rb_ren) ram_q <= ram_word(rb_raddr);
    ren_d <= rb_ren;
    if (ren_d) rb_rdata <= ram_q;
  end

  // Model: each grant taken at edge g fixes the whole schedule of the burst relative to g.
  int            e_cnt = 0;
  int            m_g = 0, m_len = 0, m_next_ok = 0;
  bit            m_valid = 1'b0;
  logic          m_owner = 1'b0, m_prio = 1'b0, win;
  logic [AW-1:0] m_addr = '0;

  always @(posedge axi_clk) begin
    e_cnt++;
    if (rst) begin
      m_valid   = 1'b0;
      m_prio    = 1'b0;
      m_next_ok = e_cnt + 1;
    end else if (e_cnt >= m_next_ok && (req0 || req1)) begin
`ifdef CMD_RBACK_ARB_RR_EN
      win = (req0 && req1) ? m_prio : req1;
`else
      win = !req0;
`endif
      m_valid   = 1'b1;
      m_g       = e_cnt;
      m_owner   = win;
      m_addr    = win ? addr1 : addr0;
      m_len     = win ? int'(len1) : int'(len0);
      m_next_ok = e_cnt + m_len + 4;
      m_prio    = ~win;
    end
  end

  int            dv0_cnt = 0, dv1_cnt = 0, dlast_cnt = 0, first_dv0 = -1;
  int            gseq[$];
  int            gcyc[$];
  logic [AW-1:0] aseq[$];

  always @(posedge axi_clk) begin
    int            d;
    logic          e_dv;
    logic [16:0]   expv, actv;
    logic [AW-1:0] ea;
    #1;
    d    = e_cnt - m_g;
    e_dv = m_valid && d >= 2 && d <= m_len + 2;
    ea   = m_valid ? m_addr + AW'((d > m_len) ? m_len : d) : '0;
    expv = {m_valid && d == 0 && !m_owner, m_valid && d == 0 && m_owner,
            e_dv && !m_owner, e_dv && m_owner, m_valid && d == m_len + 2,
            m_valid && d <= m_len, m_valid && d <= m_len + 2, ea};
    actv = {gnt0, gnt1, dvalid0, dvalid1, dlast, rb_ren, busy, rb_raddr};
    chk("cycle", actv, expv);
    if (e_dv) chk("rdata", rdata, ram_word(m_addr + AW'(d - 2)));
    if (gnt0) begin gseq.push_back(0); gcyc.push_back(e_cnt); end
    if (gnt1) begin gseq.push_back(1); gcyc.push_back(e_cnt); end
    if (dvalid0) begin dv0_cnt++; if (first_dv0 < 0) first_dv0 = e_cnt; end
    if (dvalid1) dv1_cnt++;
    if (dlast) dlast_cnt++;
    if (rb_ren) aseq.push_back(rb_raddr);
  end

  task automatic clear_mon();
    dv0_cnt = 0; dv1_cnt = 0; dlast_cnt = 0; first_dv0 = -1;
    gseq.delete(); gcyc.delete(); aseq.delete();
  endtask

  task automatic wait_gnt(input bit which);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge axi_clk);
      got = which ? gnt1 : gnt0;
    end
    chk("gnt_seen", got, 1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 400 && !idle; k++) begin
      @(negedge axi_clk);
      idle = !busy;
    end
    chk("idle_seen", idle, 1);
    @(negedge axi_clk);
  endtask

  task automatic run_burst(input bit which, input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(negedge axi_clk);
    if (which) begin req1 = 1'b1; addr1 = a; len1 = l; end
    else       begin req0 = 1'b1; addr0 = a; len0 = l; end
    wait_gnt(which);
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 10'h155; addr1 = 10'h2AA; len0 = 8'h09; len1 = 8'h0B;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge axi_clk);
    chk("reset_outputs", {gnt0, gnt1, dvalid0, dvalid1, dlast, rb_ren, busy, rb_raddr}, 0);
    rst = 1'b0;

    // Both requesters held, single-word bursts.
    clear_mon();
    @(negedge axi_clk);
    req0 = 1'b1; req1 = 1'b1; len0 = 0; len1 = 0; addr0 = 10'h040; addr1 = 10'h050;
    repeat (16) @(negedge axi_clk);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    chk("s3_ngrants", gseq.size(), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef CMD_RBACK_ARB_RR_EN
      chk("s3_grant_order", gseq[i], i % 2);
`else
      chk("s3_grant_order", gseq[i], 0);
`endif
    end

    // Four-word burst from 0x010.
    clear_mon();
    run_burst(1'b0, 10'h010, 8'd3);
    chk("s1_nreads", aseq.size(), 4);
    for (int i = 0; i < 4 && i < aseq.size(); i++) chk("s1_raddr", aseq[i], 10'h010 + i);
    chk("s1_dv0", dv0_cnt, 4);
    chk("s1_dv1", dv1_cnt, 0);
    chk("s1_dlast", dlast_cnt, 1);
    chk("s1_ngrants", gseq.size(), 1);

    // Address wrap.
    clear_mon();
    run_burst(1'b0, 10'h3FE, 8'd2);
    chk("s2_nreads", aseq.size(), 3);
    if (aseq.size() == 3) begin
      chk("s2_raddr0", aseq[0], 10'h3FE);
      chk("s2_raddr1", aseq[1], 10'h3FF);
      chk("s2_raddr2", aseq[2], 10'h000);
    end

    // req0 arrives during req1's burst and must wait for IDLE.
    clear_mon();
    @(negedge axi_clk);
    req1 = 1'b1; addr1 = 10'h200; len1 = 8'd7;
    @(negedge axi_clk);
    req1 = 1'b0; addr1 = 10'h111; len1 = 8'd1;
    repeat (2) @(negedge axi_clk);
    req0 = 1'b1; addr0 = 10'h020; len0 = 8'd1;
    wait_gnt(1'b0);
    req0 = 1'b0;
    wait_idle();
    chk("s4_dv1", dv1_cnt, 8);
    chk("s4_dv0", dv0_cnt, 2);
    chk("s4_ngrants", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("s4_first_owner", gseq[0], 1);
      chk("s4_second_owner", gseq[1], 0);
      chk("s4_gnt_gap", gcyc[1] - gcyc[0], 11);
      chk("s4_dv0_delay", first_dv0 - gcyc[1], 2);
    end

    // Reset on the second read of an eight-word burst.
    clear_mon();
    @(negedge axi_clk);
    req0 = 1'b1; addr0 = 10'h080; len0 = 8'd7;
    wait_gnt(1'b0);
    req0 = 1'b0;
    @(negedge axi_clk);
    rst = 1'b1;
    @(negedge axi_clk);
    chk("s5_reset_outputs", {gnt0, gnt1, dvalid0, dvalid1, dlast, rb_ren, busy, rb_raddr}, 0);
    rst = 1'b0;
    clear_mon();
    repeat (12) @(negedge axi_clk);
    chk("s5_no_dv0", dv0_cnt, 0);
    chk("s5_no_dv1", dv1_cnt, 0);
    chk("s5_no_dlast", dlast_cnt, 0);
    run_burst(1'b0, 10'h0F0, 8'd1);
    chk("s5_after_dv0", dv0_cnt, 2);

    // Longest burst.
    clear_mon();
    run_burst(1'b0, 10'h300, 8'hFF);
    chk("s6_dv0", dv0_cnt, 256);
    chk("s6_dlast", dlast_cnt, 1);
    chk("s6_nreads", aseq.size(), 256);
    if (aseq.size() == 256) chk("s6_last_raddr", aseq[255], 10'h3FF);

    repeat (3) @(negedge axi_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_rback_arbiter.md
CMD_RBACK_ARBITER -- requirements
Module: cmd_rback_arbiter

Interface
REQ-001 SHALL have parameter CONTROL_RBACK_DEPTH, default 10, readback RAM address width.
REQ-002 SHALL have parameter LEN_BITS, default 8, burst-length field width.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port axi_clk  input  1  clock; all logic is clocked on its rising edge.
REQ-005 SHALL have ports req0/req1  input  1 each  requester burst request, level.
REQ-006 SHALL have ports addr0/addr1  input  CONTROL_RBACK_DEPTH each  burst start word address.
REQ-007 SHALL have ports len0/len1  input  LEN_BITS each  burst length minus one.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have ports dvalid0/dvalid1  output  1 each  rdata word valid for that requester.
REQ-010 SHALL have port dlast  output  1  qualifies the final word of a burst (together with dvalid0/dvalid1).
REQ-011 SHALL have port rdata  output  32  read data, combinational pass-through of rb_rdata.
REQ-012 SHALL have port rb_raddr  output  CONTROL_RBACK_DEPTH  shared RAM read address.
REQ-013 SHALL have port rb_ren  output  1  shared RAM read enable; the RAM also uses a delayed copy as its output-register enable.
REQ-014 SHALL have port rb_rdata  input  32  RAM data, valid 2 cycles after rb_ren.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, BURST and DRAIN.
REQ-017 IDLE with any reqN high SHALL register gntN=1 for one cycle for the winner, capture its addrN/lenN, and enter BURST on the next cycle.
REQ-018 BURST SHALL assert rb_ren every cycle.
REQ-019 In BURST, rb_raddr SHALL start at the captured address and increment by 1 per cycle, wrapping modulo 2^CONTROL_RBACK_DEPTH (e.g. 0x3FF to 0x000).
REQ-020 In BURST, the word counter SHALL decrement from len; the cycle on which it reads 0 SHALL be the last rb_ren, and the FSM SHALL then enter DRAIN.
REQ-021 DRAIN SHALL last exactly 2 cycles with rb_ren=0, then return to IDLE; a new grant SHALL be possible on the IDLE cycle.
REQ-022 For each rb_ren, dvalidN of the owning requester SHALL assert exactly 2 cycles later; dlast SHALL assert with the word of the last rb_ren.
REQ-023 The owner tag SHALL be carried in a 2-stage pipeline alongside rb_ren, so that dvalid never goes to a non-owner.
REQ-024 A burst SHALL issue len+1 reads; len=0 SHALL give exactly one word, and len=2^LEN_BITS-1 SHALL give 256 words at default width.
REQ-025 Changes to reqN, addrN or lenN after the grant SHALL be ignored; a granted burst SHALL always complete.
REQ-026 A request arriving during BURST or DRAIN SHALL wait, unserved, until IDLE.
REQ-027 rb_raddr SHALL hold its last value when rb_ren=0.

Reset
REQ-028 On rst, the FSM SHALL return to IDLE and the round-robin pointer SHALL point to requester 0.
REQ-029 On rst, gnt0/1, dvalid0/1, dlast, rb_ren, busy and rb_raddr SHALL all be 0, and the tag pipeline SHALL clear.
REQ-030 Reset mid-burst SHALL abort the burst; no dvalid SHALL be produced for in-flight reads.

Configuration
REQ-031 With macro CMD_RBACK_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not served last wins, and the pointer updates on each grant.
REQ-032 Without CMD_RBACK_ARB_RR_EN, the arbiter SHALL use fixed priority, with req0 always winning over req1.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the requester-index type and the read-latency constant RBACK_RD_LATENCY=2.
REQ-034 The arbitration decision SHALL be a separate sub-module, cmd_rback_arb_pick (inputs: req0, req1, pointer; output: winner index).

Verification
REQ-035 Apply req0 with addr0=0x010, len0=3 -> gnt0 one cycle; rb_raddr 0x010..0x013 on 4 consecutive rb_ren; dvalid0 4 words, each 2 cycles after its rb_ren; dlast on word 4.
REQ-036 Apply req0 with addr0=0x3FE, len0=2 -> rb_raddr 0x3FE, 0x3FF, 0x000.
REQ-037 Hold req0 and req1 continuously, each with len=0 -> grants gnt0, gnt1, gnt0, ... with RR_EN defined; gnt0 only without it.
REQ-038 Start req1 with len1=7, then raise req0 on the 3rd BURST cycle -> req1 finishes 8 words; gnt0 in the first IDLE after DRAIN; no dvalid0 before it.
REQ-039 Assert rst on the 2nd rb_ren of an 8-word burst -> all outputs 0 the next cycle; no dvalid afterwards; the next request is served normally.
REQ-040 Apply req0 with len0=0xFF -> exactly 256 dvalid0 pulses, dlast on the last one only.
